// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control unit
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_LOAD,
    CLS_STORE, CLS_JALR, CLS_BRANCH, CLS_JAL
  } instr_class_t;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_sel_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_PASS_B = 2'd2} alu_op_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_JALR = 2'd1, PC_REL = 2'd2} pc_src_t;
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_sel_t;
  typedef enum logic [1:0] {CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_MEM_TIMEOUT = 2'd2} trap_cause_t;

  function automatic imm_sel_t imm_fmt(input instr_class_t cls);
    case (cls)
      CLS_STORE:          return IMM_S;
      CLS_BRANCH:         return IMM_B;
      CLS_JAL:            return IMM_J;
      CLS_LUI, CLS_AUIPC: return IMM_U;
      default:            return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rtl/rv_multicycle_ctrl_if.sv - memory request/ready handshake between controller and unified memory
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/rv_main_decoder.sv
// rtl/rv_main_decoder.sv - opcode to instruction class, flags anything outside the supported RV32I set
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = CLS_OP;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the shared multi-cycle RV32I datapath
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [31:0]                 instr,
  input  logic                        br_taken,
  rv_multicycle_ctrl_if.master        mem,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic [1:0]                  pc_src,
  output logic [2:0]                  imm_sel,
  output logic [1:0]                  alu_a_sel,
  output logic                        alu_b_sel,
  output logic [1:0]                  alu_op,
  output logic                        rf_we,
  output logic [1:0]                  wb_sel,
  output logic                        trap,
  output logic [1:0]                  trap_cause,
  output logic [31:0]                 instret
);

  state_t       state, state_nx;
  logic [1:0]   cause_q, cause_nx;
  logic [31:0]  wait_cnt;
  instr_class_t cls;
  logic         illegal;
  logic         req, we, addr_sel;
  logic         waiting, timeout;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^instr[31:7];

  rv_main_decoder u_dec (
    .opcode  (instr[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;

  // wait_cnt holds earlier stalled cycles, so the current stall is the MEM_TIMEOUT-th one
  assign waiting = req && !mem.mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == MEM_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_START;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state    <= state_nx;
      cause_q  <= cause_nx;
      wait_cnt <= waiting ? wait_cnt + 32'd1 : '0;
      if (pc_we) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    cause_nx   = cause_q;
    req        = 1'b0;
    we         = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    imm_sel    = IMM_I;
    alu_a_sel  = A_RS1;
    alu_b_sel  = 1'b0;
    alu_op     = ALU_ADD;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;
    case (state)
      ST_START: state_nx = ST_FETCH;
      ST_FETCH: begin
        req   = 1'b1;
        ir_we = mem.mem_ready;
        if (mem.mem_ready) begin
          state_nx = ST_DECODE;
        end else if (timeout) begin
          state_nx = ST_TRAP;
          cause_nx = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        imm_sel = imm_fmt(cls);
        if (illegal) begin
          state_nx = ST_TRAP;
          cause_nx = CAUSE_ILLEGAL;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        imm_sel  = imm_fmt(cls);
        state_nx = ST_WB;
        case (cls)
          CLS_OP: alu_op = ALU_FUNCT;
          CLS_OP_IMM: begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          CLS_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = 1'b1;
          end
          CLS_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_sel = 1'b1;
            state_nx  = ST_MEM;
          end
          CLS_JALR: alu_b_sel = 1'b1;
          CLS_BRANCH: begin
            alu_op   = ALU_FUNCT;
            pc_we    = 1'b1;
            pc_src   = br_taken ? PC_REL : PC_PLUS4;
            state_nx = ST_FETCH;
          end
          CLS_JAL: begin
            rf_we    = 1'b1;
            wb_sel   = WB_PC4;
            pc_we    = 1'b1;
            pc_src   = PC_REL;
            state_nx = ST_FETCH;
          end
          default: state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        imm_sel  = imm_fmt(cls);
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = (cls == CLS_STORE);
        if (mem.mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we    = 1'b1;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_WB;
          end
        end else if (timeout) begin
          state_nx = ST_TRAP;
          cause_nx = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_WB: begin
        imm_sel  = imm_fmt(cls);
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        state_nx = ST_FETCH;
        if (cls == CLS_LOAD) wb_sel = WB_MEM;
        else if (cls == CLS_JALR) begin
          wb_sel = WB_PC4;
          pc_src = PC_JALR;
        end
      end
      ST_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: state_nx = ST_START;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - randomized self-checking bench for rv_multicycle_ctrl against a per-instruction cycle model
module tb_rv_multicycle_ctrl;

  localparam logic [6:0] O_LOAD = 7'h03, O_OPIMM = 7'h13, O_AUIPC = 7'h17, O_STORE = 7'h23;
  localparam logic [6:0] O_OP = 7'h33, O_LUI = 7'h37, O_BR = 7'h63, O_JALR = 7'h67, O_JAL = 7'h6F;

  typedef struct packed {
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic [31:0] ins;
    bit          rdy;
    bit          bt;
    ctl_t        c;
    logic [31:0] ir;
  } cyc_t;

  logic clk = 1'b0, reset_n = 1'b0, br_taken = 1'b0;
  logic [31:0] instr = '0;
  logic ir_we, pc_we, alu_b_sel, rf_we, trap;
  logic [1:0] pc_src, alu_a_sel, alu_op, wb_sel, trap_cause;
  logic [2:0] imm_sel;
  logic [31:0] instret;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] exp_ir = '0;
  cyc_t q[$];
  ctl_t dut_ctl;

  rv_multicycle_ctrl_if bus ();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .br_taken(br_taken), .mem(bus),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_ctl              = '0;
    dut_ctl.mem_req      = bus.mem_req;
    dut_ctl.mem_we       = bus.mem_we;
    dut_ctl.mem_addr_sel = bus.mem_addr_sel;
    dut_ctl.ir_we        = ir_we;
    dut_ctl.pc_we        = pc_we;
    dut_ctl.pc_src       = pc_src;
    dut_ctl.imm_sel      = imm_sel;
    dut_ctl.alu_a_sel    = alu_a_sel;
    dut_ctl.alu_b_sel    = alu_b_sel;
    dut_ctl.alu_op       = alu_op;
    dut_ctl.rf_we        = rf_we;
    dut_ctl.wb_sel       = wb_sel;
    dut_ctl.trap         = trap;
    dut_ctl.trap_cause   = trap_cause;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic [31:0] ins, input bit rdy, input bit bt, input ctl_t c);
    cyc_t r;
    r.ins = ins; r.rdy = rdy; r.bt = bt; r.c = c; r.ir = exp_ir;
    q.push_back(r);
    if (c.pc_we) exp_ir = exp_ir + 32'd1;
  endfunction

  function automatic void push_fetch(input int wf);
    ctl_t c;
    for (int i = 0; i < wf; i++) begin
      c = '0; c.mem_req = 1'b1;
      push($urandom, 1'b0, 1'($urandom), c);
    end
    c = '0; c.mem_req = 1'b1; c.ir_we = 1'b1;
    push($urandom, 1'b1, 1'($urandom), c);
  endfunction

  // one legal instruction: fetch with wf stalls, decode, execute, optional memory phase, optional writeback
  function automatic void add_instr(input logic [31:0] ins, input int wf, input int wm, input bit bt);
    logic [6:0] op = ins[6:0];
    logic [2:0] fmt;
    ctl_t c;
    fmt = (op == O_STORE) ? 3'd1 : (op == O_BR) ? 3'd2 : (op == O_JAL) ? 3'd3 :
          (op == O_LUI || op == O_AUIPC) ? 3'd4 : 3'd0;
    push_fetch(wf);
    c = '0; c.imm_sel = fmt;
    push(ins, 1'($urandom), 1'($urandom), c);
    c = '0; c.imm_sel = fmt;
    case (op)
      O_OP:    c.alu_op = 2'd1;
      O_OPIMM: begin c.alu_b_sel = 1'b1; c.alu_op = 2'd1; end
      O_LUI:   begin c.alu_a_sel = 2'd2; c.alu_b_sel = 1'b1; end
      O_AUIPC: begin c.alu_a_sel = 2'd1; c.alu_b_sel = 1'b1; end
      O_BR:    begin c.alu_op = 2'd1; c.pc_we = 1'b1; c.pc_src = bt ? 2'd2 : 2'd0; end
      O_JAL:   begin c.rf_we = 1'b1; c.wb_sel = 2'd2; c.pc_we = 1'b1; c.pc_src = 2'd2; end
      default: c.alu_b_sel = 1'b1;
    endcase
    push(ins, 1'($urandom), bt, c);
    if (op == O_LOAD || op == O_STORE) begin
      c = '0; c.imm_sel = fmt; c.mem_req = 1'b1; c.mem_addr_sel = 1'b1; c.mem_we = (op == O_STORE);
      for (int i = 0; i < wm; i++) push(ins, 1'b0, 1'($urandom), c);
      c.pc_we = (op == O_STORE);
      push(ins, 1'b1, 1'($urandom), c);
    end
    if (op != O_BR && op != O_JAL && op != O_STORE) begin
      c = '0; c.imm_sel = fmt; c.rf_we = 1'b1; c.pc_we = 1'b1;
      c.wb_sel = (op == O_LOAD) ? 2'd1 : (op == O_JALR) ? 2'd2 : 2'd0;
      c.pc_src = (op == O_JALR) ? 2'd1 : 2'd0;
      push(ins, 1'($urandom), 1'($urandom), c);
    end
  endfunction

  function automatic void push_trap(input int n, input logic [1:0] cause);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0; c.trap = 1'b1; c.trap_cause = cause;
      push($urandom, 1'($urandom), 1'($urandom), c);
    end
  endfunction

  task automatic run_q();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      instr = r.ins; bus.mem_ready = r.rdy; br_taken = r.bt;
      #2;
      check($sformatf("ctl@%0d", cyc), 32'(dut_ctl), 32'(r.c));
      check($sformatf("instret@%0d", cyc), instret, r.ir);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.mem_ready = 1'b0;
    #2;
    check("rst_ctl", 32'(dut_ctl), 32'd0);
    check("rst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("start_ctl", 32'(dut_ctl), 32'd0);
    exp_ir = '0;
  endtask

  initial begin
    logic [6:0] ops[9] = '{O_OP, O_OPIMM, O_LUI, O_AUIPC, O_LOAD, O_STORE, O_JALR, O_BR, O_JAL};
    logic [31:0] r, saved;
    ctl_t c;
    bus.mem_ready = 1'b0;
    do_reset();

    add_instr(32'h002081B3, 0, 0, 1'b0);
    add_instr(32'h0040A103, 0, 2, 1'b0);
    add_instr(32'h00208463, 0, 0, 1'b1);
    add_instr(32'h00208463, 0, 0, 1'b0);
    add_instr(32'h002081B3, 3, 0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      add_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    run_q();

    saved = exp_ir;
    add_instr(32'h0020A223, 0, 3, 1'b0);
    void'(q.pop_back());
    exp_ir = saved;
    run_q();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    check("sw_mid_mem_req", 32'(bus.mem_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_ctl", 32'(dut_ctl), 32'd0);
    check("async_rst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_ir = '0;
    #2;
    check("restart_ctl", 32'(dut_ctl), 32'd0);
    add_instr(32'h002081B3, 0, 0, 1'b0);
    run_q();

    push_fetch(0);
    c = '0;
    push(32'h0000007F, 1'b1, 1'b0, c);
    push_trap(20, 2'd1);
    run_q();

    do_reset();
    for (int i = 0; i < 4; i++) begin
      c = '0; c.mem_req = 1'b1;
      push($urandom, 1'b0, 1'b0, c);
    end
    push_trap(3, 2'd2);
    run_q();

    do_reset();
    add_instr(32'h002081B3, 1, 0, 1'b0);
    saved = exp_ir;
    add_instr(32'h0040A103, 0, 0, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    exp_ir = saved;
    c = '0; c.mem_req = 1'b1; c.mem_addr_sel = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h0040A103, 1'b0, 1'b0, c);
    push_trap(3, 2'd2);
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
